// File: rtl/rbt_s_meta_pkt_join.sv
// Joins the parser packet stream with its per-packet metadata; metadata rides as a sideband on every beat.
// Latency 1 cycle, 1 beat/cycle; s_axis stalls while no metadata is queued or the output register is blocked.
// Optional counters under RBT_S_META_JOIN_STATS_EN; otherwise stat_* are tied to zero.
module rbt_s_meta_pkt_join #(
    parameter int DATA_WIDTH         = 512,
    parameter int KEEP_WIDTH         = DATA_WIDTH/8,
    parameter int USER_WIDTH         = 64,
    parameter int PKT_METADATA_WIDTH = 274,
    parameter int META_FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,
    input  logic                          s_meta_valid,
    output logic                          s_meta_ready,
    input  logic [PKT_METADATA_WIDTH-1:0] s_meta_info,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [PKT_METADATA_WIDTH-1:0] m_axis_tmeta,
    output logic                          m_axis_tsop,
    output logic [31:0]                   stat_pkt_count,
    output logic [31:0]                   stat_meta_wait
);

    localparam int          PW       = $clog2(META_FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(META_FIFO_DEPTH);

    typedef enum logic {ST_SOP, ST_BODY} state_t;

    logic [PKT_METADATA_WIDTH-1:0] mem_q [META_FIFO_DEPTH];
    logic [PKT_METADATA_WIDTH-1:0] mem_d [META_FIFO_DEPTH];
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]                   cnt_q, cnt_d;
    state_t                        state_q, state_d;

    logic                          vld_q, vld_d, last_q, last_d, sop_q, sop_d;
    logic [DATA_WIDTH-1:0]         dat_q, dat_d;
    logic [KEEP_WIDTH-1:0]         keep_q, keep_d;
    logic [USER_WIDTH-1:0]         user_q, user_d;
    logic [PKT_METADATA_WIDTH-1:0] meta_q, meta_d;

    logic meta_avail, out_free, in_rdy, in_acc, push, pop;
    logic [PKT_METADATA_WIDTH-1:0] head;

    always_comb begin
        meta_avail = (cnt_q != '0);
        out_free   = !vld_q | m_axis_tready;
        in_rdy     = meta_avail & out_free;
        in_acc     = s_axis_tvalid & in_rdy;
        push       = s_meta_valid & (cnt_q != FULL_CNT);
        pop        = in_acc & s_axis_tlast;
        head       = mem_q[rd_ptr_q];
    end

    // No bypass: a pushed word becomes head only from the next cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_meta_info;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        dat_d   = dat_q;
        keep_d  = keep_q;
        last_d  = last_q;
        user_d  = user_q;
        meta_d  = meta_q;
        sop_d   = sop_q;
        if (in_acc) begin
            vld_d  = 1'b1;
            dat_d  = s_axis_tdata;
            keep_d = s_axis_tkeep;
            last_d = s_axis_tlast;
            user_d = s_axis_tuser;
            // Head stays put until tlast, so body beats reuse the word latched at SOP.
            if (state_q == ST_SOP) begin
                sop_d  = 1'b1;
                meta_d = head;
            end else begin
                sop_d  = 1'b0;
                meta_d = meta_q;
            end
            state_d = s_axis_tlast ? ST_SOP : ST_BODY;
        end else if (m_axis_tready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_SOP;
            vld_q    <= 1'b0;
            dat_q    <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
            user_q   <= '0;
            meta_q   <= '0;
            sop_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            vld_q    <= vld_d;
            dat_q    <= dat_d;
            keep_q   <= keep_d;
            last_q   <= last_d;
            user_q   <= user_d;
            meta_q   <= meta_d;
            sop_q    <= sop_d;
        end
    end

    assign s_axis_tready = in_rdy;
    assign s_meta_ready  = (cnt_q != FULL_CNT);
    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = dat_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tmeta  = meta_q;
    assign m_axis_tsop   = sop_q;

`ifdef RBT_S_META_JOIN_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d, wait_cnt_q, wait_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        wait_cnt_d = wait_cnt_q;
        if (vld_q && m_axis_tready && last_q) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
        if ((state_q == ST_SOP) && s_axis_tvalid && !meta_avail) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign stat_pkt_count = pkt_cnt_q;
    assign stat_meta_wait = wait_cnt_q;
`else
    assign stat_pkt_count = '0;
    assign stat_meta_wait = '0;
`endif

endmodule
